// File: rtl/acl_ctx_ram_pkg.sv
// Shared types and default sizing for the context-partitioned ACL RAM.
package acl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } acl_clear_state_e;

  localparam int ACL_DATA_WIDTH = 8;
  localparam int ACL_ADDR_WIDTH = 12;
  localparam int ACL_CTX_WIDTH  = 2;

endpackage

// File: rtl/acl_ctx_ram_array.sv
// Storage for all contexts: one write port and two registered read ports
// (read-before-write on address collision).
module acl_ctx_ram_array #(
  parameter int ENTRY_W = 8,
  parameter int RDA_W   = ENTRY_W,
  parameter int AW      = 14
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_a_i,
  output logic [RDA_W-1:0]   rdata_a_o,
  input  logic [AW-1:0]      raddr_b_i,
  output logic [ENTRY_W-1:0] rdata_b_o
);

  logic [ENTRY_W-1:0] mem_q [2**AW];
  logic [RDA_W-1:0]   rd_a_q;
  logic [ENTRY_W-1:0] rd_b_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rd_a_q <= mem_q[raddr_a_i][RDA_W-1:0];
    rd_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rd_a_q;
  assign rdata_b_o = rd_b_q;

endmodule

// File: rtl/acl_ctx_ram.sv
// Multi-context ACL RAM: register port, lookup port and a per-context bulk clear.
// Optional per-entry even parity is enabled by defining ACL_CTX_RAM_PARITY_EN.
module acl_ctx_ram
  import acl_pkg::*;
#(
  parameter int                    DATA_WIDTH  = ACL_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = ACL_ADDR_WIDTH,
  parameter int                    CTX_WIDTH   = ACL_CTX_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [CTX_WIDTH-1:0]  reg_ctx_i,
  input  logic [ADDR_WIDTH-1:0] reg_addr_i,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  input  logic                  reg_write_i,
  output logic [DATA_WIDTH-1:0] reg_data_o,
  input  logic                  clear_req_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  input  logic [CTX_WIDTH-1:0]  active_ctx_i,
  input  logic [ADDR_WIDTH-1:0] active_addr_i,
  output logic [DATA_WIDTH-1:0] active_data_o,
  output logic                  active_perr_o
);

  localparam int RAM_AW = CTX_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

`ifdef ACL_CTX_RAM_PARITY_EN
  localparam int ENTRY_W = DATA_WIDTH + 1;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_WIDTH-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int ENTRY_W = DATA_WIDTH;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_WIDTH-1:0] d);
    return d;
  endfunction
`endif

  acl_clear_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CTX_WIDTH-1:0]    clr_ctx_q, clr_ctx_d;
  logic                    reg_fwd_q, reg_fwd_d;
  logic                    act_byp_q, act_byp_d;
  logic                    act_clr_q, act_clr_d;
  logic                    out_en_q, out_en_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic                    reg_wr_en;
  logic                    clr_wr_en;
  logic                    ram_we;
  logic [RAM_AW-1:0]       ram_waddr;
  logic [ENTRY_W-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]   rd_reg;
  logic [ENTRY_W-1:0]      rd_act;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_ctx_d = clr_ctx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req_i) begin
          state_d   = ST_CLEAR;
          clr_ctx_d = reg_ctx_i;
          cnt_d     = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes are gated by reset so an aborted clear stops at the current address.
  always_comb begin
    reg_wr_en = rst_n_i && reg_write_i && (state_q == ST_IDLE);
    clr_wr_en = rst_n_i && (state_q == ST_CLEAR);
    ram_we    = reg_wr_en || clr_wr_en;
    ram_waddr = clr_wr_en ? {clr_ctx_q, cnt_q} : {reg_ctx_i, reg_addr_i};
    ram_wdata = pack_entry(clr_wr_en ? CLEAR_VALUE : reg_data_i);

    reg_fwd_d = reg_wr_en;
    act_byp_d = reg_wr_en && (reg_ctx_i == active_ctx_i) && (reg_addr_i == active_addr_i);
    act_clr_d = (state_q == ST_CLEAR) && (active_ctx_i == clr_ctx_q);
    wr_data_d = reg_data_i;
    out_en_d  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clr_ctx_q <= '0;
      reg_fwd_q <= 1'b0;
      act_byp_q <= 1'b0;
      act_clr_q <= 1'b0;
      out_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_ctx_q <= clr_ctx_d;
      reg_fwd_q <= reg_fwd_d;
      act_byp_q <= act_byp_d;
      act_clr_q <= act_clr_d;
      out_en_q  <= out_en_d;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_data_q <= wr_data_d;
  end

  acl_ctx_ram_array #(
    .ENTRY_W (ENTRY_W),
    .RDA_W   (DATA_WIDTH),
    .AW      (RAM_AW)
  ) u_array (
    .clk_i     (clk_i),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i ({reg_ctx_i, reg_addr_i}),
    .rdata_a_o (rd_reg),
    .raddr_b_i ({active_ctx_i, active_addr_i}),
    .rdata_b_o (rd_act)
  );

  // A lookup into the context being cleared reads as cleared even before
  // the counter has reached that address.
  always_comb begin
    reg_data_o    = '0;
    active_data_o = '0;
    active_perr_o = 1'b0;
    if (out_en_q) begin
      reg_data_o = reg_fwd_q ? wr_data_q : rd_reg;
      if (act_byp_q) begin
        active_data_o = wr_data_q;
      end else if (act_clr_q) begin
        active_data_o = CLEAR_VALUE;
      end else begin
        active_data_o = rd_act[DATA_WIDTH-1:0];
`ifdef ACL_CTX_RAM_PARITY_EN
        active_perr_o = ^rd_act;
`endif
      end
    end
  end

  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = (state_q == ST_DONE);

endmodule

// File: doc/acl_ctx_ram.md
ACL_CTX_RAM -- requirements
Module: acl_ctx_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, entry width in bits.
REQ-002 Parameter ADDR_WIDTH, default 12, entry address width per context.
REQ-003 Parameter CTX_WIDTH, default 2, context select width (NUM_CTX = 2**CTX_WIDTH).
REQ-004 Parameter CLEAR_VALUE, default all-zero, value written by bulk clear.
REQ-005 clk_i  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n_i  in  1  reset, synchronous, active-low.
REQ-007 reg_ctx_i  in  CTX_WIDTH  register-port context; also selects the context for clear_req_i.
REQ-008 reg_addr_i  in  ADDR_WIDTH  register-port entry address.
REQ-009 reg_data_i  in  DATA_WIDTH  register-port write data.
REQ-010 reg_write_i  in  1  register-port write strobe.
REQ-011 reg_data_o  out  DATA_WIDTH  register-port read data.
REQ-012 clear_req_i  in  1  bulk-clear start request for context reg_ctx_i.
REQ-013 clear_busy_o  out  1  high while bulk clear is in progress.
REQ-014 clear_done_o  out  1  one-cycle pulse on bulk-clear completion.
REQ-015 active_ctx_i  in  CTX_WIDTH  lookup-port context.
REQ-016 active_addr_i  in  ADDR_WIDTH  lookup-port entry address.
REQ-017 active_data_o  out  DATA_WIDTH  lookup-port read data.
REQ-018 active_perr_o  out  1  lookup-port parity error flag.

Function
REQ-019 Storage SHALL be NUM_CTX * 2**ADDR_WIDTH entries, addressed {ctx, addr}.
REQ-020 Register port: 1-cycle latency; on reg_write_i, entry is written and reg_data_o SHALL return reg_data_i (write-first); otherwise reg_data_o SHALL return the stored entry.
REQ-021 Lookup port: 1-cycle latency; active_data_o SHALL return the stored entry for {active_ctx_i, active_addr_i}.
REQ-022 Bypass: register write and lookup to the same {ctx, addr} in the same cycle SHALL return the new data on active_data_o next cycle.
REQ-023 Clear FSM states: IDLE, CLEAR, DONE.
REQ-024 IDLE -> CLEAR on clear_req_i; latch reg_ctx_i as clear context; address counter SHALL be 0.
REQ-025 CLEAR: write CLEAR_VALUE to {clear ctx, counter} each cycle, counter +1; after address 2**ADDR_WIDTH-1, go to DONE (2**ADDR_WIDTH cycles busy).
REQ-026 DONE: clear_done_o high for exactly one cycle, then IDLE.
REQ-027 clear_busy_o SHALL be high exactly in CLEAR.
REQ-028 clear_req_i in CLEAR or DONE SHALL be ignored.
REQ-029 reg_write_i in CLEAR or DONE SHALL be dropped (no storage change); reg_data_o then returns stored contents.
REQ-030 Lookups to the clear context during CLEAR SHALL return CLEAR_VALUE; other contexts unaffected.
REQ-031 clear_req_i with reg_write_i in IDLE: the write SHALL be performed; the clear then overwrites it.

Reset
REQ-032 rst_n_i low SHALL force reg_data_o, active_data_o, active_perr_o, clear_busy_o, and clear_done_o to 0, FSM to IDLE, and counter to 0.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 Reset during CLEAR SHALL abort: context left partially cleared, no clear_done_o pulse.

Configuration
REQ-035 Macro ACL_CTX_RAM_PARITY_EN defined: each entry SHALL store an even-parity bit (written by register writes and clear); active_perr_o SHALL assert, aligned with active_data_o, on mismatch.
REQ-036 Macro undefined: no parity storage; active_perr_o SHALL be tied 0.

Structure
REQ-037 Package acl_pkg SHALL hold clear FSM state enum acl_clear_state_e and default parameter constants.
REQ-038 Sub-module acl_ctx_ram_array SHALL implement storage: one write port, two registered read ports; FSM, bypass and parity live in acl_ctx_ram.

Verification
REQ-039 Write ctx1 addr 0x010 = 0xA5, next cycle read reg and active ports -> both 0xA5 one cycle later; reg_data_o = 0xA5 in write cycle+1.
REQ-040 Same-cycle write ctx0 addr 0x003 = 0x5A and lookup ctx0 addr 0x003 -> active_data_o = 0x5A next cycle.
REQ-041 Fill ctx2 with 0xFF, clear_req_i ctx2 -> busy exactly 4096 cycles, one clear_done_o pulse, all ctx2 = 0x00, ctx3 unchanged.
REQ-042 During clear of ctx2: lookup ctx2 -> 0x00; reg write ctx3 = 0x11 -> dropped; second clear_req_i -> ignored.
REQ-043 Assert rst_n_i low at clear cycle 100 -> busy 0 next cycle, no done pulse, entries 0..99 cleared, others retain 0xFF.
REQ-044 With ACL_CTX_RAM_PARITY_EN: force-flip a stored bit, look it up -> active_perr_o = 1; macro undefined -> always 0.
